// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage with a single-outstanding data-memory handshake
// and a writeback register that bubbles while the access is in flight.
module mem_wb_stage #(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memtoReg_m,
  input  logic             memWrite_m,
  input  logic             jal_m,
  input  logic             regWrite_m,
  input  logic [DBITS-1:0] incrementedPC_m,
  input  logic [DBITS-1:0] dstReg_m,
  input  logic [DBITS-1:0] aluOut_m,
  input  logic [DBITS-1:0] dataFwdOut2_m,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DBITS-1:0] dmem_addr,
  output logic [DBITS-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DBITS-1:0] dmem_rdata,
  output logic             stall,
  output logic             regWrite_w,
  output logic [DBITS-1:0] dstReg_w,
  output logic [DBITS-1:0] wbData_w
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, nextState;
  logic memop, issue, isLoad;
  logic [DBITS-1:0] wbSel;
  assign memop = memtoReg_m | memWrite_m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = (state == IDLE) ? (memop ? ACCESS : IDLE) : (dmem_ack ? IDLE : ACCESS);
  always_comb begin
    issue  = (state == IDLE) & memop;
    stall  = issue | ((state == ACCESS) & ~dmem_ack);
    isLoad = memtoReg_m & ~memWrite_m;
    wbSel  = jal_m ? incrementedPC_m : isLoad ? dmem_rdata : aluOut_m;
  end
  // Request fields are captured once at issue and held until the ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= memWrite_m;
      dmem_addr  <= aluOut_m;
      dmem_wdata <= dataFwdOut2_m;
    end else if ((state == ACCESS) && dmem_ack) begin
      dmem_req   <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regWrite_w <= 1'b0;
      dstReg_w   <= '0;
      wbData_w   <= '0;
    end else if (stall) begin
      regWrite_w <= 1'b0;
    end else begin
      regWrite_w <= regWrite_m;
      dstReg_w   <= dstReg_m;
      wbData_w   <= wbSel;
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DBITS, default 32: width of data, address, PC and destination-register fields.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 memtoReg_m, memWrite_m, jal_m, regWrite_m  in  1 each  EX/MEM control: load, store, link, register write.
REQ-005 incrementedPC_m, dstReg_m, aluOut_m, dataFwdOut2_m  in  DBITS each  EX/MEM data: PC+4, destination register, ALU result/address, store data.
REQ-006 dmem_req  out  1  data-memory request, registered.
REQ-007 dmem_we  out  1  request is a write.
REQ-008 dmem_addr, dmem_wdata  out  DBITS each  request address and write data.
REQ-009 dmem_ack  in  1  memory completion, one-cycle pulse.
REQ-010 dmem_rdata  in  DBITS  read data, valid while dmem_ack is high.
REQ-011 stall  out  1  combinational; upstream holds EX/MEM contents while high.
REQ-012 regWrite_w  out  1  writeback enable.
REQ-013 dstReg_w, wbData_w  out  DBITS each  writeback register and value.

Function
REQ-014 FSM SHALL have two states, IDLE and ACCESS.
REQ-015 memop = memtoReg_m | memWrite_m.
REQ-016 In IDLE with memop=1, SHALL on the next edge enter ACCESS, set dmem_req=1, latch dmem_addr=aluOut_m, dmem_wdata=dataFwdOut2_m, dmem_we=memWrite_m.
REQ-017 In ACCESS, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay constant until dmem_ack=1.
REQ-018 In ACCESS with dmem_ack=1, SHALL on the next edge return to IDLE and clear dmem_req.
REQ-019 stall = (IDLE & memop) | (ACCESS & ~dmem_ack).
REQ-020 When stall=0, SHALL on the edge load regWrite_w=regWrite_m, dstReg_w=dstReg_m, wbData_w = jal_m ? incrementedPC_m : (memtoReg_m & ~memWrite_m) ? dmem_rdata : aluOut_m.
REQ-021 When stall=1, SHALL on the edge load regWrite_w=0 (bubble); dstReg_w and wbData_w hold.
REQ-022 Latency: non-memory op reaches writeback outputs 1 edge after presentation; memory op reaches them on the edge where dmem_ack=1, minimum 2 edges.
REQ-023 memtoReg_m and memWrite_m both high: treated as a store (dmem_we=1); wbData_w selects aluOut_m unless jal_m.
REQ-024 dmem_ack in IDLE SHALL be ignored: no state change, no writeback.
REQ-025 Back-to-back memory ops: after the ack edge, a new memop in IDLE SHALL issue on the following edge (one idle cycle between requests).
REQ-026 At most one outstanding request; no new request until the previous ack.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, regWrite_w=0, dstReg_w=0, wbData_w=0.
REQ-028 Reset during ACCESS SHALL abandon the request; a later dmem_ack SHALL be ignored per REQ-024.
REQ-029 After rst_n deasserts, first active edge SHALL behave as IDLE.

Verification
REQ-030 ALU op: regWrite_m=1, dstReg_m=5, aluOut_m=0x1234 -> next edge regWrite_w=1, dstReg_w=5, wbData_w=0x1234, stall=0 throughout.
REQ-031 Load: memtoReg_m=1, aluOut_m=0x100, dstReg_m=3; ack with rdata=0xCAFEBABE 3 cycles after dmem_req rises -> stall high 4 cycles; dmem_addr=0x100, dmem_we=0; on ack edge regWrite_w=1, wbData_w=0xCAFEBABE; regWrite_w=0 on all stalled edges.
REQ-032 Store: memWrite_m=1, aluOut_m=0x40, dataFwdOut2_m=0xDEAD, regWrite_m=0; ack next cycle -> dmem_we=1, dmem_wdata=0xDEAD, regWrite_w=0, state IDLE after ack.
REQ-033 jal: jal_m=1, regWrite_m=1, incrementedPC_m=0x204 -> wbData_w=0x204 next edge.
REQ-034 rst_n low during ACCESS, then spurious dmem_ack -> dmem_req=0 immediately, all outputs 0, no writeback from the spurious ack.
REQ-035 Two loads back-to-back, each acked after 1 cycle -> two distinct requests separated by one idle cycle, two writebacks with correct rdata.
